// File: rtl/collision_scan_unit_pkg.sv
// Shared widths, defaults and scan FSM states for the collision scan unit.
//   X_W/Y_W/W_W/H_W : coordinate, width and height field widths
//   CMP_W           : width of all overlap sums (wide enough that none wrap)
//   HIT_IDX_W       : width of the hit_idx output
package collision_scan_unit_pkg;

    localparam int X_W          = 11;
    localparam int Y_W          = 9;
    localparam int W_W          = 8;
    localparam int H_W          = 7;
    localparam int CMP_W        = 12;
    localparam int HIT_IDX_W    = 4;
    localparam int GROUND_Y_DEF = 200;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SCAN,
        ST_DONE
    } scan_state_e;

endpackage

// File: rtl/collision_box_cmp.sv
// Combinational overlap test between the dino box and one ground obstacle.
// Each overlap must exceed MARGIN pixels before it counts as a hit.
//   valid          : obstacle channel is live
//   dino_x/y/w/h   : dino box (top-left corner, size)
//   obs_x/w/h      : obstacle; occupies rows [GROUND_Y-obs_h, GROUND_Y)
//   hit            : boxes overlap by more than MARGIN on both axes
module collision_box_cmp
    import collision_scan_unit_pkg::*;
#(
    parameter int GROUND_Y = GROUND_Y_DEF,
    parameter int MARGIN   = 2
) (
    input  logic           valid,
    input  logic [X_W-1:0] dino_x,
    input  logic [Y_W-1:0] dino_y,
    input  logic [W_W-1:0] dino_w,
    input  logic [H_W-1:0] dino_h,
    input  logic [X_W-1:0] obs_x,
    input  logic [W_W-1:0] obs_w,
    input  logic [H_W-1:0] obs_h,
    output logic           hit
);

    logic [CMP_W-1:0] dino_right;
    logic [CMP_W-1:0] obs_left_m;
    logic [CMP_W-1:0] dino_left_m;
    logic [CMP_W-1:0] obs_right;
    logic [CMP_W-1:0] dino_bot_ext;
    logic [CMP_W-1:0] ground_m;
    logic [CMP_W-1:0] dino_top_m;

    always_comb begin
        dino_right  = CMP_W'(dino_x) + CMP_W'(dino_w);
        obs_left_m  = CMP_W'(obs_x) + CMP_W'(MARGIN);
        dino_left_m = CMP_W'(dino_x) + CMP_W'(MARGIN);
        obs_right   = CMP_W'(obs_x) + CMP_W'(obs_w);
        // dino_y+dino_h > GROUND_Y-obs_h+MARGIN, with obs_h moved to the left
        // so the obstacle top never needs a subtraction that could underflow.
        dino_bot_ext = CMP_W'(dino_y) + CMP_W'(dino_h) + CMP_W'(obs_h);
        ground_m     = CMP_W'(GROUND_Y) + CMP_W'(MARGIN);
        dino_top_m   = CMP_W'(dino_y) + CMP_W'(MARGIN);

        hit = valid && (obs_h != '0)
              && (dino_right > obs_left_m)
              && (dino_left_m < obs_right)
              && (dino_bot_ext > ground_m)
              && (dino_top_m < CMP_W'(GROUND_Y));
    end

endmodule

// File: rtl/collision_scan_unit.sv
// Per-frame hitbox checker: snapshots the dino and N_OBS obstacles on
// frame_tick, then tests one obstacle per cycle through a shared comparator.
//   frame_tick/enable : start a scan (ticks while busy are dropped, overrun set)
//   clear             : synchronous clear of collided, hit_idx, overrun
//   dino_*, obs_*     : coordinates, captured in the CAPTURE cycle
//   busy/done         : scan in progress / one-cycle end-of-scan pulse
//   frame_hit/hit_mask: result of the latest scan, valid from done
//   collided/hit_idx  : sticky hit flag and first hitting channel since clear
//   overrun           : sticky, frame_tick seen while busy
module collision_scan_unit
    import collision_scan_unit_pkg::*;
#(
    parameter int N_OBS    = 4,
    parameter int GROUND_Y = GROUND_Y_DEF,
    parameter int MARGIN   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_tick,
    input  logic                   enable,
    input  logic                   clear,
    input  logic [X_W-1:0]         dino_x,
    input  logic [Y_W-1:0]         dino_y,
    input  logic [W_W-1:0]         dino_w,
    input  logic [H_W-1:0]         dino_h,
    input  logic [N_OBS-1:0]       obs_valid,
    input  logic [X_W*N_OBS-1:0]   obs_x,
    input  logic [W_W*N_OBS-1:0]   obs_w,
    input  logic [H_W*N_OBS-1:0]   obs_h,
    output logic                   busy,
    output logic                   done,
    output logic                   frame_hit,
    output logic [N_OBS-1:0]       hit_mask,
    output logic                   collided,
    output logic [HIT_IDX_W-1:0]   hit_idx,
    output logic                   overrun
);

    localparam int IDX_W = (N_OBS > 1) ? $clog2(N_OBS) : 1;

    scan_state_e state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [N_OBS-1:0]       scan_mask_q, scan_mask_d;
    logic [N_OBS-1:0]       hit_mask_q, hit_mask_d;
    logic                   frame_hit_q, frame_hit_d;
    logic                   collided_q, collided_d;
    logic [HIT_IDX_W-1:0]   hit_idx_q, hit_idx_d;
    logic                   overrun_q, overrun_d;

    logic [X_W-1:0]         dino_x_q, dino_x_d;
    logic [Y_W-1:0]         dino_y_q, dino_y_d;
    logic [W_W-1:0]         dino_w_q, dino_w_d;
    logic [H_W-1:0]         dino_h_q, dino_h_d;
    logic [N_OBS-1:0]       obs_valid_q, obs_valid_d;
    logic [X_W*N_OBS-1:0]   obs_x_q, obs_x_d;
    logic [W_W*N_OBS-1:0]   obs_w_q, obs_w_d;
    logic [H_W*N_OBS-1:0]   obs_h_q, obs_h_d;

    logic                   cmp_hit;
    logic [N_OBS-1:0]       final_mask;
    logic [HIT_IDX_W-1:0]   first_idx;

    collision_box_cmp #(
        .GROUND_Y (GROUND_Y),
        .MARGIN   (MARGIN)
    ) u_cmp (
        .valid  (obs_valid_q[idx_q]),
        .dino_x (dino_x_q),
        .dino_y (dino_y_q),
        .dino_w (dino_w_q),
        .dino_h (dino_h_q),
        .obs_x  (obs_x_q[idx_q*X_W +: X_W]),
        .obs_w  (obs_w_q[idx_q*W_W +: W_W]),
        .obs_h  (obs_h_q[idx_q*H_W +: H_W]),
        .hit    (cmp_hit)
    );

    // Lowest set bit of the published mask; scanned downwards so the
    // last assignment is the lowest index.
    always_comb begin
        first_idx = '0;
        for (int unsigned i = N_OBS; i > 0; i--) begin
            if (hit_mask_q[i-1]) first_idx = HIT_IDX_W'(i - 1);
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        scan_mask_d = scan_mask_q;
        hit_mask_d  = hit_mask_q;
        frame_hit_d = frame_hit_q;
        collided_d  = collided_q;
        hit_idx_d   = hit_idx_q;
        overrun_d   = overrun_q;
        dino_x_d    = dino_x_q;
        dino_y_d    = dino_y_q;
        dino_w_d    = dino_w_q;
        dino_h_d    = dino_h_q;
        obs_valid_d = obs_valid_q;
        obs_x_d     = obs_x_q;
        obs_w_d     = obs_w_q;
        obs_h_d     = obs_h_q;

        final_mask         = scan_mask_q;
        final_mask[idx_q]  = cmp_hit;

        case (state_q)
            ST_IDLE: begin
                if (frame_tick && enable) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                dino_x_d    = dino_x;
                dino_y_d    = dino_y;
                dino_w_d    = dino_w;
                dino_h_d    = dino_h;
                obs_valid_d = obs_valid;
                obs_x_d     = obs_x;
                obs_w_d     = obs_w;
                obs_h_d     = obs_h;
                scan_mask_d = '0;
                idx_d       = '0;
                state_d     = ST_SCAN;
            end
            ST_SCAN: begin
                scan_mask_d = final_mask;
                if (idx_q == IDX_W'(N_OBS - 1)) begin
                    // Publish on the way into DONE so results are valid with done.
                    hit_mask_d  = final_mask;
                    frame_hit_d = |final_mask;
                    state_d     = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (clear) begin
            collided_d = 1'b0;
            hit_idx_d  = '0;
            overrun_d  = 1'b0;
        end
        // A hit in the DONE cycle overrides a coincident clear.
        if (state_q == ST_DONE && frame_hit_q) begin
            collided_d = 1'b1;
            if (!collided_q || clear) hit_idx_d = first_idx;
        end
        if (frame_tick && state_q != ST_IDLE) overrun_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            scan_mask_q <= '0;
            hit_mask_q  <= '0;
            frame_hit_q <= 1'b0;
            collided_q  <= 1'b0;
            hit_idx_q   <= '0;
            overrun_q   <= 1'b0;
            dino_x_q    <= '0;
            dino_y_q    <= '0;
            dino_w_q    <= '0;
            dino_h_q    <= '0;
            obs_valid_q <= '0;
            obs_x_q     <= '0;
            obs_w_q     <= '0;
            obs_h_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            scan_mask_q <= scan_mask_d;
            hit_mask_q  <= hit_mask_d;
            frame_hit_q <= frame_hit_d;
            collided_q  <= collided_d;
            hit_idx_q   <= hit_idx_d;
            overrun_q   <= overrun_d;
            dino_x_q    <= dino_x_d;
            dino_y_q    <= dino_y_d;
            dino_w_q    <= dino_w_d;
            dino_h_q    <= dino_h_d;
            obs_valid_q <= obs_valid_d;
            obs_x_q     <= obs_x_d;
            obs_w_q     <= obs_w_d;
            obs_h_q     <= obs_h_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign frame_hit = frame_hit_q;
    assign hit_mask  = hit_mask_q;
    assign collided  = collided_q;
    assign hit_idx   = hit_idx_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_collision_scan_unit.sv
module tb_collision_scan_unit;
    localparam int N_OBS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        enable = 1'b1;
    logic        clear = 1'b0;
    logic [10:0] dino_x = '0;
    logic [8:0]  dino_y = '0;
    logic [7:0]  dino_w = '0;
    logic [6:0]  dino_h = '0;
    logic [N_OBS-1:0]    obs_valid = '0;
    logic [11*N_OBS-1:0] obs_x = '0;
    logic [8*N_OBS-1:0]  obs_w = '0;
    logic [7*N_OBS-1:0]  obs_h = '0;
    logic        busy, done, frame_hit, collided, overrun;
    logic [N_OBS-1:0] hit_mask;
    logic [3:0]  hit_idx;

    int n_checks = 0;
    int n_fail   = 0;

    collision_scan_unit #(.N_OBS(N_OBS), .GROUND_Y(200), .MARGIN(2)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable),
        .clear(clear), .dino_x(dino_x), .dino_y(dino_y), .dino_w(dino_w),
        .dino_h(dino_h), .obs_valid(obs_valid), .obs_x(obs_x), .obs_w(obs_w),
        .obs_h(obs_h), .busy(busy), .done(done), .frame_hit(frame_hit),
        .hit_mask(hit_mask), .collided(collided), .hit_idx(hit_idx),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_dino(input int x, input int y, input int w, input int h);
        dino_x = 11'(x); dino_y = 9'(y); dino_w = 8'(w); dino_h = 7'(h);
    endtask

    task automatic set_obs(input int ch, input bit v, input int x, input int w, input int h);
        obs_valid[ch]      = v;
        obs_x[ch*11 +: 11] = 11'(x);
        obs_w[ch*8 +: 8]   = 8'(w);
        obs_h[ch*7 +: 7]   = 7'(h);
    endtask

    task automatic clear_obs();
        for (int i = 0; i < N_OBS; i++) set_obs(i, 1'b0, 0, 0, 0);
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
    endtask

    // Ticks one frame, returns tick-to-done latency and the number of done
    // pulses seen up to 8 cycles after done. Obstacles are invalidated after
    // capture to show the snapshot is used.
    task automatic run_frame(input int extra_tick_at, input bit clear_in_done,
                             output int lat, output int pulses);
        lat = 0; pulses = 0;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0; lat = 1;
        while (!done && lat < 20) begin
            if (lat == 2) obs_valid = '0;
            if (lat == extra_tick_at) frame_tick = 1'b1;
            @(negedge clk); frame_tick = 1'b0; lat++;
        end
        if (done) begin
            pulses = 1;
            if (clear_in_done) clear = 1'b1;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk); clear = 1'b0;
                if (done) pulses++;
            end
        end
    endtask

    int lat, pulses, cnt;

    initial begin
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_collided", collided, 0);
        check("rst_mask", hit_mask, 0);
        check("rst_idx", hit_idx, 0);
        check("rst_overrun", overrun, 0);
        @(negedge clk); rst_n = 1'b1;

        // enable low: tick ignored
        enable = 1'b0;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin @(negedge clk); if (busy) cnt++; end
        check("disabled_busy", cnt, 0);
        enable = 1'b1;

        // 1: basic hit on channel 2
        set_dino(50, 160, 40, 40); clear_obs(); set_obs(2, 1, 80, 20, 30);
        run_frame(-1, 0, lat, pulses);
        check("t1_latency", lat, 6);
        check("t1_mask", hit_mask, 4'b0100);
        check("t1_frame_hit", frame_hit, 1);
        check("t1_collided", collided, 1);
        check("t1_idx", hit_idx, 2);

        // 2: right-edge boundary
        pulse_clear();
        clear_obs(); set_obs(0, 1, 88, 20, 30);
        run_frame(-1, 0, lat, pulses);
        check("t2_x88_hit", frame_hit, 0);
        check("t2_x88_collided", collided, 0);
        clear_obs(); set_obs(0, 1, 87, 20, 30);
        run_frame(-1, 0, lat, pulses);
        check("t2_x87_mask", hit_mask, 4'b0001);
        check("t2_x87_idx", hit_idx, 0);
        check("t2_x87_collided", collided, 1);

        // 3: jump clears the obstacle
        pulse_clear();
        set_dino(50, 100, 40, 40); clear_obs(); set_obs(0, 1, 60, 20, 30);
        run_frame(-1, 0, lat, pulses);
        check("t3_frame_hit", frame_hit, 0);
        check("t3_collided", collided, 0);

        // 4: two hits, lowest index wins; later frame keeps first index
        set_dino(50, 160, 40, 40); clear_obs();
        set_obs(0, 1, 200, 20, 30);
        set_obs(1, 1, 60, 20, 30);
        set_obs(2, 1, 60, 20, 0);
        set_obs(3, 1, 70, 10, 20);
        run_frame(-1, 0, lat, pulses);
        check("t4_mask", hit_mask, 4'b1010);
        check("t4_idx", hit_idx, 1);
        clear_obs(); set_obs(3, 1, 70, 10, 20);
        run_frame(-1, 0, lat, pulses);
        check("t4b_mask", hit_mask, 4'b1000);
        check("t4b_idx", hit_idx, 1);

        // 5: overrun, then clear coinciding with DONE of a hit frame
        pulse_clear();
        clear_obs(); set_obs(1, 1, 60, 20, 30);
        run_frame(2, 0, lat, pulses);
        check("t5_latency", lat, 6);
        check("t5_pulses", pulses, 1);
        check("t5_overrun", overrun, 1);
        check("t5_idx", hit_idx, 1);
        clear_obs(); set_obs(3, 1, 70, 10, 20);
        run_frame(-1, 1, lat, pulses);
        check("t5_clear_collided", collided, 1);
        check("t5_clear_idx", hit_idx, 3);
        check("t5_clear_overrun", overrun, 0);

        // 6: async reset in the middle of a scan
        clear_obs(); set_obs(1, 1, 60, 20, 30);
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_collided", collided, 0);
        check("t6_mask", hit_mask, 0);
        check("t6_idx", hit_idx, 0);
        check("t6_frame_hit", frame_hit, 0);
        @(negedge clk); rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin @(negedge clk); if (done) cnt++; end
        check("t6_no_done", cnt, 0);
        clear_obs(); set_obs(3, 1, 70, 10, 20);
        run_frame(-1, 0, lat, pulses);
        check("t6_latency", lat, 6);
        check("t6_mask_after", hit_mask, 4'b1000);
        check("t6_idx_after", hit_idx, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
